// File: rtl/trace_buffer.sv
// Trace recorder for the multicycle CPU. It captures {OF, ZF, F, Inst} on every
// commit into a circular buffer, and on freeze lets the operator step through the entries.
module trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic [31:0]       Inst_code,
    input  logic [31:0]       CPU_F,
    input  logic              CPU_ZF,
    input  logic              CPU_OF,
    input  logic              freeze,
    input  logic              step,
    input  logic [2:0]        SW,
    output logic [7:0]        LED,
    output logic              cur_ZF,
    output logic              cur_OF,
    output logic [ADDR_W-1:0] rd_idx,
    output logic [ADDR_W:0]   count,
    output logic              reviewing,
    output logic              wrapped,
    output logic              lost
);

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_REVIEW  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
    logic                wrapped_q, wrapped_d;
    logic                lost_q, lost_d;
    logic                step_prev_q, step_prev_d;
    logic [7:0]          led_q, led_d;
    logic                cur_zf_q, cur_zf_d;
    logic                cur_of_q, cur_of_d;

    logic [65:0]         mem_q [DEPTH];
    logic                mem_we;
    logic                step_rise;
    logic [ADDR_W-1:0]   rd_addr;
    logic [65:0]         entry;

    // Entry layout {OF, ZF, F[31:0], Inst[31:0]}
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {CPU_OF, CPU_ZF, CPU_F, Inst_code};
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        wrapped_d   = wrapped_q;
        lost_d      = lost_q;
        step_prev_d = step;
        mem_we      = 1'b0;
        step_rise   = step & ~step_prev_q;

        case (state_q)
            ST_CAPTURE: begin
                if (commit) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (count_q < DEPTH_C) begin
                        count_d = count_q + (ADDR_W + 1)'(1);
                    end else begin
                        wrapped_d = 1'b1;
                    end
                end
                if (freeze) begin
                    state_d  = ST_REVIEW;
                    rd_idx_d = '0;
                end
            end
            ST_REVIEW: begin
                // Leaving review wins over a simultaneous step and clears the buffer
                if (!freeze) begin
                    state_d   = ST_CAPTURE;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    rd_idx_d  = '0;
                    wrapped_d = 1'b0;
                    lost_d    = 1'b0;
                end else begin
                    if (commit) begin
                        lost_d = 1'b1;
                    end
                    if (step_rise && (count_q != '0)) begin
                        if ({1'b0, rd_idx_q} == count_q - (ADDR_W + 1)'(1)) begin
                            rd_idx_d = '0;
                        end else begin
                            rd_idx_d = rd_idx_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    // Display path: cursor entry in review, newest entry in capture
    always_comb begin
        if (state_q == ST_REVIEW) begin
            rd_addr = wr_ptr_q - count_q[ADDR_W-1:0] + rd_idx_q;
        end else begin
            rd_addr = wr_ptr_q - ADDR_W'(1);
        end
        entry    = mem_q[rd_addr];
        led_d    = 8'h00;
        cur_zf_d = 1'b0;
        cur_of_d = 1'b0;
        if (count_q != '0) begin
            led_d    = entry[{SW, 3'b000} +: 8];
            cur_zf_d = entry[64];
            cur_of_d = entry[65];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CAPTURE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rd_idx_q    <= '0;
            wrapped_q   <= 1'b0;
            lost_q      <= 1'b0;
            step_prev_q <= 1'b0;
            led_q       <= 8'h00;
            cur_zf_q    <= 1'b0;
            cur_of_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            wrapped_q   <= wrapped_d;
            lost_q      <= lost_d;
            step_prev_q <= step_prev_d;
            led_q       <= led_d;
            cur_zf_q    <= cur_zf_d;
            cur_of_q    <= cur_of_d;
        end
    end

    assign LED       = led_q;
    assign cur_ZF    = cur_zf_q;
    assign cur_OF    = cur_of_q;
    assign rd_idx    = rd_idx_q;
    assign count     = count_q;
    assign reviewing = (state_q == ST_REVIEW);
    assign wrapped   = wrapped_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a one-row-per-cycle vector table, followed by
// hand-written overflow and asynchronous-reset sequences.
module tb_trace_buffer;

    logic        clk;
    logic        rst;
    logic        commit;
    logic [31:0] Inst_code;
    logic [31:0] CPU_F;
    logic        CPU_ZF;
    logic        CPU_OF;
    logic        freeze;
    logic        step;
    logic [2:0]  SW;
    logic [7:0]  LED;
    logic        cur_ZF;
    logic        cur_OF;
    logic [3:0]  rd_idx;
    logic [4:0]  count;
    logic        reviewing;
    logic        wrapped;
    logic        lost;

    int n_checks = 0;
    int n_fail   = 0;

    trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .Inst_code (Inst_code),
        .CPU_F     (CPU_F),
        .CPU_ZF    (CPU_ZF),
        .CPU_OF    (CPU_OF),
        .freeze    (freeze),
        .step      (step),
        .SW        (SW),
        .LED       (LED),
        .cur_ZF    (cur_ZF),
        .cur_OF    (cur_OF),
        .rd_idx    (rd_idx),
        .count     (count),
        .reviewing (reviewing),
        .wrapped   (wrapped),
        .lost      (lost)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cm;
        logic [31:0] inst;
        logic [31:0] f;
        logic        zf;
        logic        of;
        logic        fr;
        logic        st;
        logic [2:0]  sw;
        logic [7:0]  e_led;
        logic        e_zf;
        logic        e_of;
        logic [3:0]  e_rd;
        logic [4:0]  e_cnt;
        logic        e_rev;
        logic        e_wrp;
        logic        e_lst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic cm, input logic [31:0] inst, input logic [31:0] f,
        input logic zf, input logic of, input logic fr, input logic st,
        input logic [2:0] sw, input logic [7:0] e_led, input logic e_zf,
        input logic e_of, input logic [3:0] e_rd, input logic [4:0] e_cnt,
        input logic e_rev, input logic e_wrp, input logic e_lst);
        vec_t v;
        v.cm = cm; v.inst = inst; v.f = f; v.zf = zf; v.of = of;
        v.fr = fr; v.st = st; v.sw = sw;
        v.e_led = e_led; v.e_zf = e_zf; v.e_of = e_of; v.e_rd = e_rd;
        v.e_cnt = e_cnt; v.e_rev = e_rev; v.e_wrp = e_wrp; v.e_lst = e_lst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, outputs are sampled on the next one
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic cm, input logic [31:0] inst, input logic [31:0] f,
                         input logic zf, input logic of, input logic fr,
                         input logic st, input logic [2:0] sw);
        commit = cm; Inst_code = inst; CPU_F = f; CPU_ZF = zf; CPU_OF = of;
        freeze = fr; step = st; SW = sw;
    endtask

    task automatic step_pulse();
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset / capture / review / clear / boundary table
        //               cm inst          f      zf of fr st sw  led    zf of rd cnt rv wr ls
        vecs.push_back(mk(1, 32'h1,        32'h10, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h2,        32'h20, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 32'h3,        32'h30, 0, 0, 0, 0, 0, 8'h02, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h03, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 4, 8'h30, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 4, 8'h10, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h10, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 4, 8'h20, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h20, 0, 0, 2, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 4, 8'h30, 0, 0, 2, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h30, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 4, 8'h10, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h10, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h20, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h20, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h20, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 4, 8'h20, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 0, 8'h02, 0, 0, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 32'h99,       32'h0,  0, 0, 1, 0, 0, 8'h02, 0, 0, 1, 3, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h02, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h55,       32'h0,  1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h55, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 0, 8'h55, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h55, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hAABBCCDD, 32'h0,  0, 0, 1, 0, 3, 8'h00, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 3, 8'hAA, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 3, 8'hAA, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("reset led", LED, 8'h00);
        chk("reset count", count, 5'd0);
        chk("reset reviewing", reviewing, 1'b0);
        chk("reset wrapped", wrapped, 1'b0);
        chk("reset lost", lost, 1'b0);
        rst = 1'b1;
        cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cm, vecs[i].inst, vecs[i].f, vecs[i].zf, vecs[i].of,
                  vecs[i].fr, vecs[i].st, vecs[i].sw);
            cycle();
            chk($sformatf("row%0d led", i), LED, vecs[i].e_led);
            chk($sformatf("row%0d cur_zf", i), cur_ZF, vecs[i].e_zf);
            chk($sformatf("row%0d cur_of", i), cur_OF, vecs[i].e_of);
            chk($sformatf("row%0d rd_idx", i), rd_idx, vecs[i].e_rd);
            chk($sformatf("row%0d count", i), count, vecs[i].e_cnt);
            chk($sformatf("row%0d reviewing", i), reviewing, vecs[i].e_rev);
            chk($sformatf("row%0d wrapped", i), wrapped, vecs[i].e_wrp);
            chk($sformatf("row%0d lost", i), lost, vecs[i].e_lst);
        end

        // Overflow: 18 commits into a 16-entry buffer
        for (int k = 1; k <= 18; k++) begin
            drive(1, 32'(k), 32'h0, 0, 0, 0, 0, 0);
            cycle();
            if (k == 16) begin
                chk("ovf count at 16", count, 5'd16);
                chk("ovf wrapped at 16", wrapped, 1'b0);
            end
            if (k == 17) begin
                chk("ovf wrapped at 17", wrapped, 1'b1);
                chk("ovf count at 17", count, 5'd16);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        chk("ovf reviewing", reviewing, 1'b1);
        chk("ovf count", count, 5'd16);
        chk("ovf wrapped", wrapped, 1'b1);
        chk("ovf rd_idx start", rd_idx, 4'd0);
        cycle();
        chk("ovf oldest led", LED, 8'h03);
        for (int p = 0; p < 15; p++) step_pulse();
        chk("ovf rd_idx 15", rd_idx, 4'd15);
        chk("ovf newest led", LED, 8'h12);
        step_pulse();
        chk("ovf rd_idx wrap", rd_idx, 4'd0);
        chk("ovf wrap led", LED, 8'h03);
        freeze = 1'b0;
        cycle();
        chk("ovf clear count", count, 5'd0);
        chk("ovf clear wrapped", wrapped, 1'b0);
        chk("ovf clear reviewing", reviewing, 1'b0);

        // Asynchronous reset while reviewing five entries
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h11 + 32'(k), 32'h0, 1, 0, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        step_pulse();
        chk("arst pre count", count, 5'd5);
        chk("arst pre rd_idx", rd_idx, 4'd1);
        chk("arst pre led", LED, 8'h12);
        chk("arst pre cur_zf", cur_ZF, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst led", LED, 8'h00);
        chk("arst cur_zf", cur_ZF, 1'b0);
        chk("arst cur_of", cur_OF, 1'b0);
        chk("arst rd_idx", rd_idx, 4'd0);
        chk("arst count", count, 5'd0);
        chk("arst reviewing", reviewing, 1'b0);
        chk("arst wrapped", wrapped, 1'b0);
        chk("arst lost", lost, 1'b0);
        freeze = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("post arst count", count, 5'd0);
        chk("post arst reviewing", reviewing, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
